// File: rtl/key_event_gen_if.sv
// Key event signal bundle: prescaler tick and key level in, event pulses and HELD level out.
interface key_event_gen_if;
    logic CE_IN;
    logic KEY_IN;
    logic PRESS_PULSE;
    logic SHORT_PULSE;
    logic LONG_PULSE;
    logic REPEAT_PULSE;
    logic RELEASE_PULSE;
    logic HELD;

    modport master (
        output CE_IN, KEY_IN,
        input  PRESS_PULSE, SHORT_PULSE, LONG_PULSE, REPEAT_PULSE, RELEASE_PULSE, HELD
    );

    modport slave (
        input  CE_IN, KEY_IN,
        output PRESS_PULSE, SHORT_PULSE, LONG_PULSE, REPEAT_PULSE, RELEASE_PULSE, HELD
    );
endinterface

// File: rtl/key_event_gen.sv
// Debounced key level to press/short/long/repeat/release pulses, timed in CE_IN ticks.
// Define KEYEVT_ACCEL_EN to halve the repeat period after ACCEL_AFTER repeat pulses.
module key_event_gen #(
    parameter int unsigned HOLD_TICKS   = 50,
    parameter int unsigned REPEAT_TICKS = 10,
    parameter int unsigned ACCEL_AFTER  = 8
) (
    input logic            CLK,
    input logic            CLR,
    key_event_gen_if.slave kif
);
    localparam int unsigned TMAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
    localparam int unsigned TW   = $clog2(TMAX + 1);
    localparam int unsigned RW   = (ACCEL_AFTER < 1) ? 1 : $clog2(ACCEL_AFTER + 1);

    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_TICKS - 1);
    localparam logic [TW-1:0] SLOW_LAST = TW'(REPEAT_TICKS - 1);
    localparam logic [RW-1:0] REP_MAX   = RW'(ACCEL_AFTER);
`ifdef KEYEVT_ACCEL_EN
    localparam int unsigned   FAST_TICKS = ((REPEAT_TICKS >> 1) > 0) ? (REPEAT_TICKS >> 1) : 1;
    localparam logic [TW-1:0] FAST_LAST  = TW'(FAST_TICKS - 1);
`endif

    typedef enum logic [1:0] {
        WAIT_REL,
        IDLE,
        PRESSED,
        REPEAT
    } state_e;

    state_e        state_q;
    logic [TW-1:0] tick_q, tick_d;
    logic [RW-1:0] rep_q, rep_d;
    logic [TW-1:0] period_last_d;
    logic          press_q, short_q, long_q, repeat_q, release_q, held_q;

    always_comb begin
        tick_d = tick_q + 1'b1;
        rep_d  = (rep_q == REP_MAX) ? rep_q : rep_q + 1'b1;
`ifdef KEYEVT_ACCEL_EN
        period_last_d = (rep_q == REP_MAX) ? FAST_LAST : SLOW_LAST;
`else
        period_last_d = SLOW_LAST;
`endif
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q   <= WAIT_REL;
            tick_q    <= '0;
            rep_q     <= '0;
            press_q   <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            release_q <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            release_q <= 1'b0;
            unique case (state_q)
                // A key held through reset must be seen released before it can press.
                WAIT_REL: begin
                    if (!kif.KEY_IN) state_q <= IDLE;
                end
                IDLE: begin
                    if (kif.KEY_IN) begin
                        state_q <= PRESSED;
                        press_q <= 1'b1;
                        held_q  <= 1'b1;
                        tick_q  <= '0;
                    end
                end
                PRESSED: begin
                    if (!kif.KEY_IN) begin
                        state_q   <= IDLE;
                        short_q   <= 1'b1;
                        release_q <= 1'b1;
                        held_q    <= 1'b0;
                    end else if (kif.CE_IN) begin
                        if (tick_q == HOLD_LAST) begin
                            state_q  <= REPEAT;
                            long_q   <= 1'b1;
                            repeat_q <= 1'b1;
                            tick_q   <= '0;
                            rep_q    <= RW'(1);
                        end else begin
                            tick_q <= tick_d;
                        end
                    end
                end
                REPEAT: begin
                    if (!kif.KEY_IN) begin
                        state_q   <= IDLE;
                        release_q <= 1'b1;
                        held_q    <= 1'b0;
                        rep_q     <= '0;
                    end else if (kif.CE_IN) begin
                        if (tick_q == period_last_d) begin
                            repeat_q <= 1'b1;
                            tick_q   <= '0;
                            rep_q    <= rep_d;
                        end else begin
                            tick_q <= tick_d;
                        end
                    end
                end
                default: state_q <= WAIT_REL;
            endcase
        end
    end

    assign kif.PRESS_PULSE   = press_q;
    assign kif.SHORT_PULSE   = short_q;
    assign kif.LONG_PULSE    = long_q;
    assign kif.REPEAT_PULSE  = repeat_q;
    assign kif.RELEASE_PULSE = release_q;
    assign kif.HELD          = held_q;
endmodule

// File: tb/tb_key_event_gen.sv
// Directed bench for key_event_gen: HOLD_TICKS=4, REPEAT_TICKS=2, ACCEL_AFTER=3, CE_IN every 4 CLK.
module tb_key_event_gen;
    logic CLK = 1'b0;
    logic CLR;

    key_event_gen_if kif ();

    key_event_gen #(
        .HOLD_TICKS  (4),
        .REPEAT_TICKS(2),
        .ACCEL_AFTER (3)
    ) dut (
        .CLK(CLK),
        .CLR(CLR),
        .kif(kif)
    );

    always #5 CLK = ~CLK;

    int n_assert = 0;
    int n_fail   = 0;
    int ce_cnt   = 0;
    int cyc      = 0;
    int n_press, n_short, n_long, n_rep, n_rel, n_held, n_bad;
    int last_rep, press_cyc, long_cyc;
    int gaps[$];

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int outs();
        return {26'd0, kif.PRESS_PULSE, kif.SHORT_PULSE, kif.LONG_PULSE,
                kif.REPEAT_PULSE, kif.RELEASE_PULSE, kif.HELD};
    endfunction

    task automatic clr_counts();
        n_press = 0; n_short = 0; n_long = 0; n_rep = 0; n_rel = 0; n_held = 0; n_bad = 0;
        last_rep = -1; press_cyc = -1; long_cyc = -1;
        gaps.delete();
    endtask

    // One CLK cycle with the given key level; outputs sampled 1 time unit after the edge.
    task automatic clk1(input logic key);
        kif.KEY_IN = key;
        kif.CE_IN  = (ce_cnt == 3);
        ce_cnt     = (ce_cnt + 1) % 4;
        @(posedge CLK);
        #1;
        cyc++;
        if (kif.PRESS_PULSE) begin n_press++; press_cyc = cyc; end
        if (kif.SHORT_PULSE) n_short++;
        if (kif.LONG_PULSE) begin n_long++; long_cyc = cyc; end
        if (kif.RELEASE_PULSE) n_rel++;
        if (kif.HELD) n_held++;
        if (kif.REPEAT_PULSE) begin
            n_rep++;
            if (last_rep >= 0) gaps.push_back(cyc - last_rep);
            last_rep = cyc;
        end
        if ((kif.SHORT_PULSE && !kif.RELEASE_PULSE) || (kif.LONG_PULSE && !kif.REPEAT_PULSE) ||
            (kif.REPEAT_PULSE && kif.RELEASE_PULSE) ||
            (kif.PRESS_PULSE && (kif.SHORT_PULSE || kif.LONG_PULSE || kif.REPEAT_PULSE || kif.RELEASE_PULSE)))
            n_bad++;
    endtask

    task automatic run(input logic key, input int n);
        for (int i = 0; i < n; i++) clk1(key);
    endtask

    // Next clk1 call will be phase 0 (no CE); CE lands on the 3rd, 7th, ... cycles after it.
    task automatic align(input logic key);
        while (ce_cnt != 0) clk1(key);
    endtask

    initial begin
        CLR = 1'b1;
        kif.KEY_IN = 1'b1;
        kif.CE_IN  = 1'b0;
        clr_counts();

        // 1: key held through reset never presses
        run(1'b1, 3);
        chk("reset_outputs", outs(), 0);
        CLR = 1'b0;
        clr_counts();
        run(1'b1, 40);
        run(1'b0, 3);
        chk("held_thru_reset_pulses", n_press + n_short + n_long + n_rep + n_rel, 0);
        chk("held_thru_reset_held", n_held, 0);
        clk1(1'b1);
        chk("press_after_release", kif.PRESS_PULSE, 1);
        clk1(1'b1);
        chk("press_one_cycle", kif.PRESS_PULSE, 0);
        run(1'b0, 4);

        // 2: short press of 2 ticks
        align(1'b0);
        clr_counts();
        clk1(1'b1);
        chk("short_held_at_press", kif.HELD, 1);
        run(1'b1, 8);
        clk1(1'b0);
        chk("short_pulse_release", {kif.SHORT_PULSE, kif.RELEASE_PULSE, kif.LONG_PULSE, kif.REPEAT_PULSE}, 4'b1100);
        run(1'b0, 3);
        chk("short_press_count", n_press, 1);
        chk("short_long_rep_count", n_long + n_rep, 0);
        chk("short_held_cycles", n_held, 9);
        chk("short_held_after", kif.HELD, 0);

        // 3: hold 4 + 6 ticks
        align(1'b0);
        clr_counts();
        clk1(1'b1);
        run(1'b1, 40);
        chk("long_latency", long_cyc - press_cyc, 15);
        chk("long_count", n_long, 1);
`ifdef KEYEVT_ACCEL_EN
        chk("hold10_rep_count", n_rep, 5);
`else
        chk("hold10_rep_count", n_rep, 4);
`endif
        chk("hold10_gap0", (gaps.size() > 0) ? gaps[0] : -1, 8);
        chk("hold10_gap1", (gaps.size() > 1) ? gaps[1] : -1, 8);
        clk1(1'b0);
        chk("long_release", {kif.SHORT_PULSE, kif.RELEASE_PULSE}, 2'b01);
        run(1'b0, 3);
        chk("long_rel_count", n_rel, 1);
        chk("long_short_count", n_short, 0);

        // 4: release coincides with the 4th tick -> release wins
        align(1'b0);
        clr_counts();
        clk1(1'b1);
        run(1'b1, 14);
        clk1(1'b0);
        chk("race_pulses", {kif.SHORT_PULSE, kif.RELEASE_PULSE, kif.LONG_PULSE, kif.REPEAT_PULSE}, 4'b1100);
        run(1'b0, 3);
        chk("race_long_rep_count", n_long + n_rep, 0);

        // 5: reset during REPEAT
        align(1'b0);
        clr_counts();
        clk1(1'b1);
        run(1'b1, 24);
        chk("in_repeat_long_seen", n_long, 1);
        CLR = 1'b1;
        clk1(1'b1);
        chk("clr_mid_repeat_outputs", outs(), 0);
        CLR = 1'b0;
        clr_counts();
        run(1'b1, 20);
        chk("after_clr_pulses", n_press + n_short + n_long + n_rep + n_rel + n_held, 0);
        run(1'b0, 2);
        clk1(1'b1);
        chk("after_clr_repress", kif.PRESS_PULSE, 1);
        run(1'b0, 3);

        // 6: long hold, repeat spacing (accelerated when the macro is defined)
        align(1'b0);
        clr_counts();
        clk1(1'b1);
        run(1'b1, 56);
        clk1(1'b0);
`ifdef KEYEVT_ACCEL_EN
        chk("hold14_rep_count", n_rep, 9);
        chk("hold14_gap2", (gaps.size() > 2) ? gaps[2] : -1, 4);
        chk("hold14_gap_last", (gaps.size() > 0) ? gaps[gaps.size() - 1] : -1, 4);
`else
        chk("hold14_rep_count", n_rep, 6);
        chk("hold14_gap2", (gaps.size() > 2) ? gaps[2] : -1, 8);
        chk("hold14_gap_last", (gaps.size() > 0) ? gaps[gaps.size() - 1] : -1, 8);
`endif
        chk("hold14_gap1", (gaps.size() > 1) ? gaps[1] : -1, 8);
        chk("hold14_gap_count", gaps.size(), n_rep - 1);
        chk("hold14_release", kif.RELEASE_PULSE, 1);
        run(1'b0, 2);
        chk("pair_rules", n_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
